debounce_filter: RTL

Multi-channel push-button conditioner for the chronometer front panel. It synchronises each raw input into the `clk` domain through a configurable flop chain and applies optional per-channel polarity inversion. It then accepts a level change only after the input has held steady for a programmable number of sample ticks. It sits between the board pins and the control FSM and supplies clean levels plus single-cycle press/release strobes.

---
 rtl/debounce_pkg.sv | 11 +
 rtl/debounce_chan.sv | 67 ++++++
 rtl/debounce_filter.sv | 35 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and width helper for the push-button debouncer
package debounce_pkg;

  // 50 MHz system clock, 10 ms settle window
  localparam int DEFAULT_STABLE_TICKS = 500000;

  function automatic int cnt_width(input int ticks);
    return (ticks > 2) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounced channel: sync chain, inversion, qualify counter, strobes
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter bit INV          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   level_d, rise_d, fall_d;
  logic                   s;

  // Sync flops idle at INV so the conditioned sample reads released out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= {SYNC_STAGES{INV}};
    else     sync <= {sync[SYNC_STAGES-2:0], in};
  end

  assign s = sync[SYNC_STAGES-1] ^ INV;

  always_comb begin
    cnt_d   = cnt;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == level) begin
      cnt_d = '0;
    end else if (sample_en) begin
      if (cnt == LAST) begin
        level_d = s;
        cnt_d   = '0;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt   <= cnt_d;
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

endmodule

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - multi-channel push-button conditioner for the front panel
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int                  CHANNELS     = 4,
  parameter int                  SYNC_STAGES  = 2,
  parameter int                  STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter logic [CHANNELS-1:0] INVERT       = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS),
      .INV         (INVERT[i])
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .sample_en(sample_en),
      .in       (in[i]),
      .level    (level[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

endmodule
